regn_pipe: RTL

//  Parametrised multi-stage register pipeline: N-bit generalisation of the 4-bit
//  d/q register, with a per-stage valid bit, stall (hold), flush and occupancy count.

---
 rtl/regn_pipe.sv | 38 +++
 1 files changed

// File: rtl/regn_pipe.sv
// regn_pipe: fixed-latency register pipeline with per-stage valid, stall, flush and occupancy count
module regn_pipe #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 3,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   localparam int CW = $clog2(DEPTH+1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   input  logic             valid_in,
   input  logic             stall,
   input  logic             flush,
   output logic [WIDTH-1:0] q,
   output logic             valid_out,
   output logic [CW-1:0]    count
);
   logic [WIDTH-1:0] data [DEPTH];
   logic [DEPTH-1:0] vld;
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         data  <= '{default: RESET_VAL};
         vld   <= '0;
         count <= '0;
      end else if (!stall) begin
         for (int i = DEPTH-1; i > 0; i--) begin
            data[i] <= data[i-1];
            vld[i]  <= vld[i-1];
         end
         data[0] <= d;
         vld[0]  <= valid_in;
         // count tracks popcount(vld): one word enters, the last stage's word leaves
         count   <= count + CW'(valid_in) - CW'(vld[DEPTH-1]);
      end
   end
   assign q         = data[DEPTH-1];
   assign valid_out = vld[DEPTH-1];
endmodule
